regfile_wb_queue: RTL and testbench
===================================

# regfile_wb_queue

Writeback queue sitting in front of the 32×32 register file's single write port. It accepts register writes from two producers, the ALU and the load/store unit, with a valid/ready handshake. It buffers them in a small in-order FIFO and drains one entry per cycle onto the regfile write port (`w_enable`/`w_reg_name`/`w_reg_val`). It also returns bypass values for the two read-port register names, so decode sees writes that are still queued and not yet committed.

## Interface
- `DEPTH`, 4, FIFO entries; power of two, ≥2
- `clk` in 1: clock; all state updates on posedge
- `rst` in 1: synchronous, active-high reset
- `alu_valid` in 1: ALU write request
- `alu_ready` out 1: ALU request accepted this cycle
- `alu_rd` in 5: ALU destination register
- `alu_val` in 32: ALU result
- `lsu_valid` in 1: LSU write request
- `lsu_ready` out 1: LSU request accepted this cycle
- `lsu_rd` in 5: LSU destination register
- `lsu_val` in 32: load data
- `wb_hold` in 1: suppresses draining; the port is borrowed elsewhere this cycle
- `w_enable` out 1: regfile write enable
- `w_reg_name` out 5: regfile write register
- `w_reg_val` out 32: regfile write data
- `r1_reg_name` in 5: read-port-1 name to look up
- `r1_byp_hit` out 1: a queued write to `r1_reg_name` exists
- `r1_byp_val` out 32: youngest queued value for `r1_reg_name`; 0 when no hit
- `r2_reg_name` in 5: read-port-2 name to look up
- `r2_byp_hit` out 1: same as `r1_byp_hit`, for port 2
- `r2_byp_val` out 32: same as `r1_byp_val`, for port 2
- `count` out $clog2(DEPTH)+1: occupied entries
- `empty` out 1: `count==0`
- `full` out 1: `count==DEPTH`

## Operation
- Storage: DEPTH entries of {name[4:0], val[31:0]}, plus head pointer, tail pointer and count. Pointers wrap modulo DEPTH.
- `pop = !empty && !wb_hold && !rst`.
- `space = !full || pop`.
- At most one enqueue per cycle. LSU has priority.
  - `lsu_ready = space && !rst`.
  - `alu_ready = space && !lsu_valid && !rst`.
- A handshake occurs when valid and ready are both high.
- Writes to x0 are handshaken but not enqueued. An accepted rd=0 request changes no state.
- Drain side:
  - `w_enable = pop`.
  - `w_reg_name`/`w_reg_val` = head entry when non-empty, else 0.
  - The regfile commits on negedge mid-cycle; the head is freed at the following posedge.
- Count update: +1 on enqueue only, −1 on pop only, unchanged on both or neither.
- Bypass (combinational):
  - Search all occupied entries, including the head currently being written.
  - On multiple matches, the entry nearest the tail wins.
  - `r*_reg_name==0` never hits.
  - A request being handshaken this cycle is not visible to bypass until the next cycle.
- No internal FSM beyond the FIFO. The states are EMPTY / PARTIAL / FULL, derived from `count`.

## Timing
- Reset values: `count=0`, `empty=1`, `full=0`, `w_enable=0`, `w_reg_name=0`, `w_reg_val=0`, both `byp_hit=0`, both `byp_val=0`.
- While `rst` is high, both readies are 0.
- Reset mid-operation discards every pending entry with no regfile write. `w_enable` is 0 in the `rst` cycle even if entries exist.
- Enqueue-to-write latency: an entry enqueued at posedge N drives `w_enable` in cycle N+1 if the queue was empty and `wb_hold=0`.
- Enqueue-to-bypass latency: the same entry is visible to bypass from cycle N+1.
- Full boundary: when `full` and pop are both high, an enqueue is accepted and `count` stays at DEPTH.
- Full with `wb_hold=1`: both readies are 0.
- Empty boundary: `pop` is never asserted when empty, so `count` never underflows.
- Wrap-around: after DEPTH×k operations, pointer wrap must not corrupt order or bypass age.
- Throughput: one write per cycle sustained.

## Test plan
- **Reset state:** assert `rst` 2 cycles, then release -> `empty=1`, `count=0`, `w_enable=0`, `alu_ready=1`, `lsu_ready=1`.
- **Single write:** ALU writes x5=0x1234 at cycle 0 -> cycle 1 shows `w_enable=1`, `w_reg_name=5`, `w_reg_val=0x1234`, and `r1_reg_name=5` gives `r1_byp_hit=1` with value 0x1234; cycle 2 shows `empty=1`.
- **Fill and drain:** hold `wb_hold=1` and enqueue x1..x4 (values 0x11..0x44) -> `full=1`, both readies 0. Release the hold -> four consecutive writes x1..x4 in order. Then wrap: 6 more writes in order, no loss.
- **Priority and x0:**
  - Both requesters valid (ALU x3=0xA, LSU x3=0xB) -> LSU accepted first, ALU next cycle; x3 bypass gives 0xA once both are queued.
  - LSU write to x0 is accepted with no `count` change.
- **Full with simultaneous pop:** queue full, `wb_hold=0`, LSU valid -> `lsu_ready=1` and `count` stays 4.
- **Reset mid-operation:** 3 entries queued, `rst` high for 1 cycle -> no `w_enable` in that cycle, `count=0` after, bypass misses on all three names.

Source files
------------

// File: rtl/regfile_wb_queue.sv
// rtl/regfile_wb_queue.sv - in-order writeback queue with read-port bypass for the 32x32 regfile
module regfile_wb_queue #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       alu_valid,
  output logic                       alu_ready,
  input  logic [4:0]                 alu_rd,
  input  logic [31:0]                alu_val,
  input  logic                       lsu_valid,
  output logic                       lsu_ready,
  input  logic [4:0]                 lsu_rd,
  input  logic [31:0]                lsu_val,
  input  logic                       wb_hold,
  output logic                       w_enable,
  output logic [4:0]                 w_reg_name,
  output logic [31:0]                w_reg_val,
  input  logic [4:0]                 r1_reg_name,
  output logic                       r1_byp_hit,
  output logic [31:0]                r1_byp_val,
  input  logic [4:0]                 r2_reg_name,
  output logic                       r2_byp_hit,
  output logic [31:0]                r2_byp_val,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [4:0]    names [DEPTH];
  logic [31:0]   vals  [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;

  logic          pop;
  logic          space;
  logic          lsu_fire;
  logic          alu_fire;
  logic          enq;
  logic [4:0]    enq_rd;
  logic [31:0]   enq_val;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  // A pop frees the head slot at the same edge, so a full queue can still accept.
  assign pop   = !empty && !wb_hold && !rst;
  assign space = !full || pop;

  assign lsu_ready = space && !rst;
  assign alu_ready = space && !lsu_valid && !rst;
  assign lsu_fire  = lsu_valid && lsu_ready;
  assign alu_fire  = alu_valid && alu_ready;

  assign enq_rd  = lsu_fire ? lsu_rd  : alu_rd;
  assign enq_val = lsu_fire ? lsu_val : alu_val;
  // x0 writes complete the handshake but are dropped here.
  assign enq     = (lsu_fire || alu_fire) && (enq_rd != 5'd0);

  assign w_enable   = pop;
  assign w_reg_name = empty ? 5'd0  : names[head];
  assign w_reg_val  = empty ? 32'd0 : vals[head];

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq) begin
        names[tail] <= enq_rd;
        vals[tail]  <= enq_val;
        tail        <= tail + 1'b1;
      end
      if (pop) begin
        head <= head + 1'b1;
      end
      case ({enq, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Walk oldest to youngest so the last match (nearest the tail) wins.
  always_comb begin
    logic [AW-1:0] idx;
    idx        = head;
    r1_byp_hit = 1'b0;
    r1_byp_val = 32'd0;
    r2_byp_hit = 1'b0;
    r2_byp_val = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + AW'(i);
      if (CW'(i) < count) begin
        if ((r1_reg_name != 5'd0) && (names[idx] == r1_reg_name)) begin
          r1_byp_hit = 1'b1;
          r1_byp_val = vals[idx];
        end
        if ((r2_reg_name != 5'd0) && (names[idx] == r2_reg_name)) begin
          r2_byp_hit = 1'b1;
          r2_byp_val = vals[idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_queue.sv
// tb/tb_regfile_wb_queue.sv - scoreboard bench for regfile_wb_queue with a queue-based reference model
module tb_regfile_wb_queue;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [4:0]  n;
    logic [31:0] v;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, lsu_valid, wb_hold;
  logic        alu_ready, lsu_ready;
  logic [4:0]  alu_rd, lsu_rd, r1_reg_name, r2_reg_name, w_reg_name;
  logic [31:0] alu_val, lsu_val, w_reg_val, r1_byp_val, r2_byp_val;
  logic        w_enable, r1_byp_hit, r2_byp_hit, empty, full;
  logic [2:0]  count;

  int   n_vec  = 0;
  int   n_fail = 0;
  bit   chk_en = 1'b0;
  ent_t mq[$];
  ent_t exp_q[$];

  regfile_wb_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_val(alu_val),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_val(lsu_val),
    .wb_hold(wb_hold),
    .w_enable(w_enable), .w_reg_name(w_reg_name), .w_reg_val(w_reg_val),
    .r1_reg_name(r1_reg_name), .r1_byp_hit(r1_byp_hit), .r1_byp_val(r1_byp_val),
    .r2_reg_name(r2_reg_name), .r2_byp_hit(r2_byp_hit), .r2_byp_val(r2_byp_val),
    .count(count), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", nm, $time, act, exp);
    end
  endtask

  function automatic logic [32:0] byp(input logic [4:0] n);
    logic [32:0] r;
    r = '0;
    foreach (mq[i]) if (n != 5'd0 && mq[i].n == n) r = {1'b1, mq[i].v};
    return r;
  endfunction

  // Reference model: compare every output mid-cycle, then advance to the post-edge state.
  always @(negedge clk) begin
    int          sz;
    bit          ep, sp, er_l, er_a;
    logic [32:0] b1, b2;
    sz   = mq.size();
    ep   = (sz > 0) && !wb_hold && !rst;
    sp   = (sz < DEPTH) || ep;
    er_l = sp && !rst;
    er_a = sp && !lsu_valid && !rst;
    b1   = byp(r1_reg_name);
    b2   = byp(r2_reg_name);
    if (chk_en) begin
      chk("lsu_ready", lsu_ready, er_l);
      chk("alu_ready", alu_ready, er_a);
      chk("w_enable", w_enable, ep);
      chk("w_reg_name", w_reg_name, sz > 0 ? mq[0].n : 5'd0);
      chk("w_reg_val", w_reg_val, sz > 0 ? mq[0].v : 32'd0);
      chk("count", count, sz);
      chk("empty", empty, sz == 0);
      chk("full", full, sz == DEPTH);
      chk("r1_byp_hit", r1_byp_hit, b1[32]);
      chk("r1_byp_val", r1_byp_val, b1[31:0]);
      chk("r2_byp_hit", r2_byp_hit, b2[32]);
      chk("r2_byp_val", r2_byp_val, b2[31:0]);
    end
    if (rst) begin
      mq.delete();
      exp_q.delete();
    end else begin
      if (ep) void'(mq.pop_front());
      if (lsu_valid && er_l) begin
        if (lsu_rd != 5'd0) begin
          mq.push_back('{lsu_rd, lsu_val});
          exp_q.push_back('{lsu_rd, lsu_val});
        end
      end else if (alu_valid && er_a && alu_rd != 5'd0) begin
        mq.push_back('{alu_rd, alu_val});
        exp_q.push_back('{alu_rd, alu_val});
      end
    end
  end

  // Writeback monitor: every regfile write must match the oldest expected entry.
  always @(negedge clk) begin
    ent_t e;
    if (chk_en && w_enable === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL wb_unexpected at %0t: got write x%0d=0x%0h, expected none", $time, w_reg_name, w_reg_val);
      end else begin
        e = exp_q.pop_front();
        chk("wb_order_name", w_reg_name, e.n);
        chk("wb_order_val", w_reg_val, e.v);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; wb_hold = 1'b0; alu_valid = 1'b0; lsu_valid = 1'b0;
  endtask

  task automatic alu_req(input logic [4:0] rd, input logic [31:0] v);
    alu_valid = 1'b1; alu_rd = rd; alu_val = v;
  endtask

  task automatic lsu_req(input logic [4:0] rd, input logic [31:0] v);
    lsu_valid = 1'b1; lsu_rd = rd; lsu_val = v;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    alu_rd = '0; alu_val = '0; lsu_rd = '0; lsu_val = '0;
    r1_reg_name = '0; r2_reg_name = '0;
    tick();
    chk_en = 1'b1;
    tick();
    idle();
    @(negedge clk);
    chk("reset_count", count, 0);
    chk("reset_alu_ready", alu_ready, 1);
    chk("reset_lsu_ready", lsu_ready, 1);

    // single write
    tick();
    alu_req(5'd5, 32'h1234); r1_reg_name = 5'd5;
    tick();
    idle();
    @(negedge clk);
    chk("single_w_enable", w_enable, 1);
    chk("single_w_val", w_reg_val, 32'h1234);
    chk("single_byp_val", r1_byp_val, 32'h1234);
    tick();
    @(negedge clk);
    chk("single_empty_after", empty, 1);

    // fill under hold, then drain and wrap
    tick();
    for (int i = 1; i <= 4; i++) begin
      wb_hold = 1'b1; alu_req(5'(i), 32'(i * 'h11));
      tick();
    end
    alu_req(5'd9, 32'h99);
    @(negedge clk);
    chk("fill_full", full, 1);
    chk("fill_alu_ready", alu_ready, 0);
    chk("fill_lsu_ready", lsu_ready, 0);
    tick();
    idle();
    for (int i = 0; i < 4; i++) tick();
    for (int i = 0; i < 6; i++) begin
      alu_req(5'($urandom_range(1, 31)), $urandom);
      tick();
    end
    idle();
    for (int i = 0; i < 3; i++) tick();

    // priority and x0
    wb_hold = 1'b1;
    alu_req(5'd3, 32'hA); lsu_req(5'd3, 32'hB);
    tick();
    lsu_valid = 1'b0;
    tick();
    alu_valid = 1'b0; r1_reg_name = 5'd3;
    @(negedge clk);
    chk("prio_byp_x3", r1_byp_val, 32'hA);
    tick();
    lsu_req(5'd0, 32'hDEAD);
    tick();
    lsu_valid = 1'b0;
    @(negedge clk);
    chk("x0_count", count, 2);
    tick();
    idle();
    for (int i = 0; i < 3; i++) tick();

    // full with simultaneous pop
    for (int i = 0; i < 4; i++) begin
      wb_hold = 1'b1; alu_req(5'(20 + i), $urandom);
      tick();
    end
    idle();
    lsu_req(5'd7, 32'h77);
    @(negedge clk);
    chk("fullpop_lsu_ready", lsu_ready, 1);
    tick();
    lsu_valid = 1'b0; wb_hold = 1'b1;
    @(negedge clk);
    chk("fullpop_count", count, 4);
    tick();
    idle();
    for (int i = 0; i < 5; i++) tick();

    // reset mid-operation
    for (int i = 0; i < 3; i++) begin
      wb_hold = 1'b1; alu_req(5'(10 + i), $urandom);
      tick();
    end
    idle();
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_w_enable", w_enable, 0);
    tick();
    idle();
    wb_hold = 1'b1; r1_reg_name = 5'd10; r2_reg_name = 5'd12;
    @(negedge clk);
    chk("midrst_count", count, 0);
    chk("midrst_byp1", r1_byp_hit, 0);
    chk("midrst_byp2", r2_byp_hit, 0);
    tick();
    r1_reg_name = 5'd11;
    @(negedge clk);
    chk("midrst_byp_x11", r1_byp_hit, 0);
    tick();

    // randomized traffic
    for (int i = 0; i < 500; i++) begin
      rst       = ($urandom_range(0, 59) == 0);
      wb_hold   = ($urandom_range(0, 2) == 0);
      alu_valid = 1'($urandom_range(0, 1));
      lsu_valid = ($urandom_range(0, 3) == 0);
      alu_rd    = 5'($urandom_range(0, 7));
      lsu_rd    = 5'($urandom_range(0, 7));
      alu_val   = $urandom;
      lsu_val   = $urandom;
      r1_reg_name = 5'($urandom_range(0, 7));
      r2_reg_name = 5'($urandom_range(0, 7));
      tick();
    end
    idle();
    for (int i = 0; i < DEPTH + 2; i++) tick();
    @(negedge clk);
    chk("drain_leftover", exp_q.size(), 0);
    chk("drain_empty", empty, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
